// File: rtl/req_init_pkg.sv
// ----------------------------------------------------------------------------
// req_init_pkg
// Shared types and constants for the req/gnt initiator.
//   req_init_state_t : FSM state encoding (IDLE / REQ / GAP)
//   GAP_CNT_W        : width of the inter-request gap counter (GAP_CYC 0..15)
// ----------------------------------------------------------------------------
package req_init_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } req_init_state_t;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/cyc_down_counter.sv
// ----------------------------------------------------------------------------
// cyc_down_counter
// Loadable down-counter that saturates at zero.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   load       : load load_val this cycle (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one (ignored when already zero)
//   count      : current value
//   zero       : count == 0
//   last       : count == 1, i.e. the next decrement reaches zero
// ----------------------------------------------------------------------------
module cyc_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero,
    output logic         last
);

    // Saturating at zero means the counter can never wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);
    assign last = (count == W'(1));

endmodule

// File: rtl/req_initiator.sv
// ----------------------------------------------------------------------------
// req_initiator
// Initiator side of a single-wire req/gnt handshake. Takes a command from a
// valid/ready port, raises req with the latched payload, waits for a
// qualified grant, pulses done, then idles GAP_CYC cycles before the next
// accept.
// Optional feature macro: REQ_TIMEOUT_EN -- when defined, a request that is
// not granted within TIMEOUT_CYC cycles is aborted (done with done_err=1).
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   cmd_valid  : upstream command present
//   cmd_data   : command payload
//   cmd_ready  : block accepts a command this cycle (IDLE)
//   req        : registered request to the responder
//   req_data   : latched payload, stable while req is high
//   gnt        : grant from the responder
//   done       : one-cycle completion pulse
//   done_err   : qualifies done, 1 = aborted by timeout
//   busy       : state is not IDLE
// ----------------------------------------------------------------------------
module req_initiator
    import req_init_pkg::*;
#(
    parameter int CMD_W       = 8,
    parameter int GAP_CYC     = 1,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             cmd_valid,
    input  logic [CMD_W-1:0] cmd_data,
    output logic             cmd_ready,
    output logic             req,
    output logic [CMD_W-1:0] req_data,
    input  logic             gnt,
    output logic             done,
    output logic             done_err,
    output logic             busy
);

    req_init_state_t state, next_state;

    logic accept;
    logic qual;
    logic grant;
    logic timeout_hit;
    logic finish;

    logic [GAP_CNT_W-1:0] gap_count;
    logic                 gap_zero;
    logic                 gap_last;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_ready && cmd_valid;

    // gnt only counts once req has been high a full cycle, so a grant still
    // lingering from the previous transaction cannot complete this one.
    assign grant  = (state == REQ) && qual && gnt;
    assign finish = grant || timeout_hit;

`ifdef REQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_count;
    logic            to_zero;
    logic            to_last;
    logic            done_err_r;

    // Loaded at accept and stepped every ungranted REQ cycle; abort fires on
    // the edge where it would hit zero, giving exactly TIMEOUT_CYC cycles of req.
    cyc_down_counter #(.W(TO_W)) u_timeout (
        .clk      (clk),
        .rstn     (rstn),
        .load     (accept),
        .load_val (TO_W'(TIMEOUT_CYC)),
        .dec      ((state == REQ) && !grant),
        .count    (to_count),
        .zero     (to_zero),
        .last     (to_last)
    );

    // A grant on the same edge as the timeout wins.
    assign timeout_hit = (state == REQ) && !grant && (to_last || to_zero);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            done_err_r <= 1'b0;
        end else begin
            done_err_r <= timeout_hit;
        end
    end

    assign done_err = done_err_r;
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;

    assign timeout_hit = 1'b0;
    assign done_err    = 1'b0;
`endif

    // Gap counter: loaded when REQ ends, counts down while in GAP.
    cyc_down_counter #(.W(GAP_CNT_W)) u_gap (
        .clk      (clk),
        .rstn     (rstn),
        .load     (finish),
        .load_val (GAP_CNT_W'(GAP_CYC)),
        .dec      (state == GAP),
        .count    (gap_count),
        .zero     (gap_zero),
        .last     (gap_last)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = REQ;
            REQ:  if (finish) next_state = (GAP_CYC == 0) ? IDLE : GAP;
            GAP:  if (gap_last || gap_zero) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // req, payload, qualifier and done pulse. qual is cleared in the accept
    // cycle and becomes 1 after the first REQ cycle.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req      <= 1'b0;
            req_data <= '0;
            qual     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= finish;
            qual <= (state == REQ) && !finish;
            if (accept) begin
                req      <= 1'b1;
                req_data <= cmd_data;
            end else if (finish) begin
                req <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_req_initiator.sv
module tb_req_initiator;

    logic       clk;
    logic       rstn;
    logic       cmd_valid;
    logic [7:0] cmd_data;
    logic       cmd_ready;
    logic       req;
    logic [7:0] req_data;
    logic       gnt;
    logic       done;
    logic       done_err;
    logic       busy;

    // Registered responder plus an override used for directed gnt patterns.
    logic resp_gnt;
    logic force_en;
    logic force_val;

    int checks;
    int fails;

    typedef struct {
        logic       cv;
        logic [7:0] cd;
        logic       fe;
        logic       fv;
        logic       e_ready;
        logic       e_req;
        logic [7:0] e_data;
        logic       e_done;
        logic       e_err;
        logic       e_busy;
    } vec_t;

    vec_t vecs [11];

    req_initiator #(
        .CMD_W       (8),
        .GAP_CYC     (1),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .cmd_valid (cmd_valid),
        .cmd_data  (cmd_data),
        .cmd_ready (cmd_ready),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .done      (done),
        .done_err  (done_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Responder registers req one cycle late and drops gnt when req falls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            resp_gnt <= 1'b0;
        end else begin
            resp_gnt <= req;
        end
    end

    assign gnt = force_en ? force_val : resp_gnt;

    // Compare one value and count the result.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock: outputs are then sampled mid-cycle at the negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one table row, check its expected outputs, then clock it in.
    task automatic applyStimulus(input int idx);
        vec_t v;
        v         = vecs[idx];
        cmd_valid = v.cv;
        cmd_data  = v.cd;
        force_en  = v.fe;
        force_val = v.fv;
        #1;
        checkOutput($sformatf("vec%0d.cmd_ready", idx), cmd_ready, v.e_ready);
        checkOutput($sformatf("vec%0d.req", idx),       req,       v.e_req);
        checkOutput($sformatf("vec%0d.req_data", idx),  req_data,  v.e_data);
        checkOutput($sformatf("vec%0d.done", idx),      done,      v.e_done);
        checkOutput($sformatf("vec%0d.done_err", idx),  done_err,  v.e_err);
        checkOutput($sformatf("vec%0d.busy", idx),      busy,      v.e_busy);
        tick();
    endtask

    initial begin
        int acc [3];
        int n_acc;
        int n_done;
        int n_busy_low;
        int hi;
        bit seen;
        logic [29:0] busy_hist;

        checks    = 0;
        fails     = 0;
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        force_en  = 1'b0;
        force_val = 1'b0;

        // Single 0x5A command, then a command with stale/forced gnt in IDLE and
        // first REQ cycle which must not complete early.
        //            cv    cd     fe    fv    rdy   req   data   done  err   busy
        vecs[0]  = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("rst.req",       req,       1'b0);
        checkOutput("rst.req_data",  req_data,  8'h00);
        checkOutput("rst.done",      done,      1'b0);
        checkOutput("rst.done_err",  done_err,  1'b0);
        checkOutput("rst.busy",      busy,      1'b0);
        checkOutput("rst.cmd_ready", cmd_ready, 1'b1);
        rstn = 1'b1;
        tick();

        $display("[TB] directed vector table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(i);
        end

        // Back-to-back: cmd_valid held high for three commands.
        $display("[TB] back-to-back commands");
        n_acc     = 0;
        n_done    = 0;
        busy_hist = '0;
        acc       = '{0, 0, 0};
        for (int cyc = 0; cyc < 30; cyc++) begin
            cmd_valid = (n_acc < 3);
            cmd_data  = 8'h10 + 8'(n_acc);
            #1;
            busy_hist[cyc] = busy;
            if (done) n_done++;
            if (cmd_valid && cmd_ready) begin
                acc[n_acc] = cyc;
                n_acc++;
            end
            tick();
        end
        cmd_valid = 1'b0;
        n_busy_low = 0;
        for (int cyc = acc[0]; cyc <= acc[2]; cyc++) begin
            if (!busy_hist[cyc]) n_busy_low++;
        end
        checkOutput("b2b.accepts",   n_acc,           3);
        checkOutput("b2b.spacing01", acc[1] - acc[0], 4);
        checkOutput("b2b.spacing12", acc[2] - acc[1], 4);
        checkOutput("b2b.dones",     n_done,          3);
        checkOutput("b2b.busy_low",  n_busy_low,      3);
        checkOutput("b2b.last_data", req_data,        8'h12);

`ifdef REQ_TIMEOUT_EN
        // gnt held low: abort after exactly 16 req cycles.
        $display("[TB] timeout abort");
        force_en  = 1'b1;
        force_val = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 8'h77;
        tick();
        cmd_valid = 1'b0;
        hi   = 0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            if (done) begin
                seen = 1'b1;
                checkOutput("to.done_err", done_err, 1'b1);
                checkOutput("to.gap_busy", busy,     1'b1);
            end else begin
                if (req) hi++;
                tick();
            end
        end
        checkOutput("to.done_seen", seen, 1'b1);
        checkOutput("to.req_cycles", hi, 16);
        tick();
        checkOutput("to.idle_ready", cmd_ready, 1'b1);
        checkOutput("to.idle_done",  done,      1'b0);

        // Grant arriving on the timeout edge wins.
        $display("[TB] grant coincident with timeout");
        cmd_valid = 1'b1;
        cmd_data  = 8'h88;
        tick();
        cmd_valid = 1'b0;
        repeat (15) tick();
        force_val = 1'b1;
        #1;
        checkOutput("race.req_before", req,  1'b1);
        checkOutput("race.done_early", done, 1'b0);
        tick();
        force_en  = 1'b0;
        force_val = 1'b0;
        checkOutput("race.done",     done,     1'b1);
        checkOutput("race.done_err", done_err, 1'b0);
        n_done = 0;
        tick();
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (done) n_done++;
            tick();
        end
        checkOutput("race.no_second_done", n_done, 0);
`else
        // Without the timeout, an ungranted request waits indefinitely.
        $display("[TB] no-timeout wait");
        force_en  = 1'b1;
        force_val = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 8'h77;
        tick();
        cmd_valid = 1'b0;
        n_done = 0;
        hi     = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (done) n_done++;
            if (req) hi++;
            tick();
        end
        checkOutput("wait.no_done",   n_done, 0);
        checkOutput("wait.req_held",  hi,     30);
        checkOutput("wait.req_data",  req_data, 8'h77);
        force_en = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 5 && !seen; cyc++) begin
            tick();
            if (done) begin
                seen = 1'b1;
                checkOutput("wait.done_err", done_err, 1'b0);
            end
        end
        checkOutput("wait.done_seen", seen, 1'b1);
        repeat (2) tick();
`endif

        // Reset asserted while req is high.
        $display("[TB] reset during request");
        force_en  = 1'b0;
        cmd_valid = 1'b1;
        cmd_data  = 8'h99;
        tick();
        cmd_valid = 1'b0;
        checkOutput("arst.req_before", req, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("arst.req",       req,       1'b0);
        checkOutput("arst.done",      done,      1'b0);
        checkOutput("arst.cmd_ready", cmd_ready, 1'b1);
        @(negedge clk);
        rstn   = 1'b1;
        n_done = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (done) n_done++;
            tick();
        end
        checkOutput("arst.no_done",    n_done,    0);
        checkOutput("arst.ready_post", cmd_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/req_initiator.md
# req_initiator

Initiator side of the single-wire req/gnt handshake whose responder registers `gnt` one cycle after `req` and drops it when `req` falls. Accepts commands from an upstream valid/ready port, raises `req`, holds it until a qualified `gnt`, then reports completion. An optional timeout aborts requests that are never granted. Sits between a command source and any req/gnt responder in the design.

## Interface
- `CMD_W`, 8: width of command payload carried on `req_data`.
- `GAP_CYC`, 1: idle cycles forced between `req` fall and the next accept (0..15).
- `TIMEOUT_CYC`, 16: cycles `req` may stay high without grant before abort (>=2; used only with `REQ_TIMEOUT_EN`).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  upstream command present.
- `cmd_data`  in  CMD_W  command payload.
- `cmd_ready`  out  1  block can accept a command this cycle.
- `req`  out  1  request to responder (registered).
- `req_data`  out  CMD_W  latched payload, stable while `req`=1.
- `gnt`  in  1  grant from responder.
- `done`  out  1  one-cycle completion pulse (registered).
- `done_err`  out  1  qualifies `done`: 1 = aborted by timeout.
- `busy`  out  1  state != IDLE.

## Operation
- States: IDLE, REQ, GAP (enum in package).
- IDLE: `cmd_ready`=1 (combinational from state). On `cmd_valid && cmd_ready` at an edge: latch `cmd_data` into `req_data`, `req`<=1, clear qualifier and timeout count, go REQ.
- REQ: `cmd_ready`=0. Grant qualifier `q` sets after `req` has been high one full cycle; `gnt` sampled only when `q`=1 (stale `gnt` from a previous transaction is ignored).
  - `gnt && q`: `req`<=0, `done`<=1, `done_err`<=0, go GAP (or IDLE if `GAP_CYC`=0).
  - Timeout (macro on): count increments each REQ cycle without qualified grant; at count == `TIMEOUT_CYC` with no qualified `gnt`: `req`<=0, `done`<=1, `done_err`<=1, go GAP/IDLE. Same-cycle grant and timeout: grant wins, `done_err`=0.
- GAP: down-counter loaded with `GAP_CYC` on REQ exit; decrements each cycle; go IDLE when it reaches 1→0 transition (exactly `GAP_CYC` cycles in GAP). `gnt` ignored.
- `gnt` in IDLE/GAP has no effect.
- `req_data` holds its value after `req` falls until the next accept.
- Counter widths: `$clog2(TIMEOUT_CYC+1)` and 4 bits; no wrap possible (saturating compare).

## Timing
- Reset (async assert, sync release): state IDLE, `req`=0, `req_data`=0, `done`=0, `done_err`=0, counters 0, `busy`=0, `cmd_ready`=1.
- Accept at edge N → `req`=1 in cycle N+1. With registered responder, `gnt`=1 in N+2, sampled at its end → `req`=0 and `done`=1 in N+3.
- Minimum issue-to-issue spacing: 3 + `GAP_CYC` cycles.
- `done` is high exactly one cycle; `done_err` valid only with `done`, 0 otherwise.
- Reset mid-REQ: `req` drops immediately (async), no `done` generated.

## Configuration
- `REQ_TIMEOUT_EN`: defined → timeout counter and abort path present, `TIMEOUT_CYC` honoured. Undefined → counter removed, REQ waits indefinitely for grant, `done_err` tied 0.

## Structure
- Package `req_init_pkg`: state enum `req_init_state_t` (IDLE/REQ/GAP), localparam for gap counter width.
- One sub-module `cyc_down_counter` (load, decrement, zero flag; width parameter) instantiated for the gap counter and, under the macro, for the timeout.

## Test plan
- Single command 0x5A with registered responder, `GAP_CYC`=1 → `req` high cycles N+1..N+2, `done`=1/`done_err`=0 at N+3, `req_data`=0x5A throughout.
- Back-to-back `cmd_valid` held high, 3 commands → accepts spaced exactly 4 cycles apart; three `done` pulses, `busy` low only in accept cycles.
- `gnt` tied 0, `TIMEOUT_CYC`=16, macro on → `req` high 16 cycles, then `done`=1, `done_err`=1, return to IDLE after gap.
- Grant arriving the same cycle timeout hits → `done_err`=0, no second `done`.
- `gnt` forced 1 in IDLE and first REQ cycle → no early completion; completion only after qualified sample.
- `rstn` pulsed low while `req`=1 → `req`=0 asynchronously, no `done`, `cmd_ready`=1 after release.
